fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 31 +++
 rtl/fetch_queue.sv | 76 +++++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: datapath widths, PC
// step, fetch-queue depth, the FSM state type, the queue entry layout and a
// PC alignment helper.
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned PC_W         = 32;
    localparam int unsigned INST_W       = 32;
    localparam logic [PC_W-1:0] PC_INC   = 32'd4;
    localparam int unsigned FETCH_QDEPTH = 2;
    // Occupancy counter must hold 0..FETCH_QDEPTH inclusive.
    localparam int unsigned CNT_W        = 2;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & ~(PC_W'(3));
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Two-entry FIFO holding fetched {pc, inst} pairs between fetch and decode.
// Push and pop may happen in the same cycle (count unchanged); flush empties
// the queue and takes priority over push/pop.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   push_i            write push_pc_i/push_inst_i at the tail
//   pop_i             advance the head
//   flush_i           drop all entries
//   push_pc_i         address of the instruction being pushed
//   push_inst_i       instruction word being pushed
//   count_o           number of valid entries (0..2)
//   head_pc_o         address at the head entry
//   head_inst_o       instruction word at the head entry
//
// The caller never pushes into a full queue unless it also pops that cycle,
// and never pops an empty queue.
// ----------------------------------------------------------------------------
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_QDEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic [PC_W-1:0]   push_pc_i,
    input  logic [INST_W-1:0] push_inst_i,
    output logic [CNT_W-1:0]  count_o,
    output logic [PC_W-1:0]   head_pc_o,
    output logic [INST_W-1:0] head_inst_o
);

    fetch_entry_t       mem_q [DEPTH];
    // With two entries a single toggling bit is a complete pointer.
    logic               wr_ptr_q;
    logic               rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // NOTE: the storage is reset along with the pointers so that the head
    // outputs read a defined zero entry out of reset rather than X.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= '{pc: push_pc_i, inst: push_inst_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign count_o     = count_q;
    assign head_pc_o   = mem_q[rd_ptr_q].pc;
    assign head_inst_o = mem_q[rd_ptr_q].inst;

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end. Holds the PC, drives it to a combinational
// instruction memory, and pushes the returned word together with its address
// into a two-entry queue that feeds decode through a valid/ready handshake.
// A redirect (taken branch/jump) flushes the queue and reloads the PC.
//
// Ports
//   Clk             clock
//   Clrn            asynchronous active-low reset
//   InstAddr        fetch address (current PC)
//   Inst            instruction word for InstAddr, same cycle
//   RedirectValid   load PC from RedirectTarget, flush queue
//   RedirectTarget  redirect address (low two bits ignored)
//   OutValid        queue head is valid
//   OutReady        decode accepts the head this cycle
//   OutInst         head instruction word
//   OutPc           head instruction address
//   OutPcPlus4      OutPc + 4 (wraps)
//   StallCnt        cycles with OutValid && !OutReady (saturating)
//
// Build option: define FETCH_PERF_EN to implement the StallCnt counter;
// without it StallCnt is tied to zero.
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        Clk,
    input  logic        Clrn,
    output logic [31:0] InstAddr,
    input  logic [31:0] Inst,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    output logic        OutValid,
    input  logic        OutReady,
    output logic [31:0] OutInst,
    output logic [31:0] OutPc,
    output logic [31:0] OutPcPlus4,
    output logic [31:0] StallCnt
);

    fetch_state_e       state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;

    logic [CNT_W-1:0]   q_count;
    logic [PC_W-1:0]    head_pc;
    logic [INST_W-1:0]  head_inst;

    logic               q_full;
    logic               deq;
    logic               enq;
    logic               pop;

    assign q_full   = (q_count == CNT_W'(QDEPTH));
    assign OutValid = (q_count != '0);
    assign deq      = OutValid && OutReady;

    // Redirect wins over everything: no enqueue, and a handshake that
    // happens in the same cycle is dropped together with the flushed queue.
    // A full queue can still accept a new word when the head leaves this cycle.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        enq  = 1'b0;
        pop  = 1'b0;
        pc_d = pc_q;
        if (RedirectValid) begin
            pc_d = align_pc(RedirectTarget);
        end else begin
            pop = deq;
            if (state_q == RUN && (!q_full || deq)) begin
                enq  = 1'b1;
                pc_d = pc_q + PC_INC;
            end
        end
    end

    // BOOT lasts exactly one cycle after reset; a redirect also lands in RUN,
    // so every path out of either state leads to RUN.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            pc_q <= pc_d;
            case (state_q)
                BOOT:    state_q <= RUN;
                RUN:     state_q <= RUN;
                default: state_q <= BOOT;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk         (Clk),
        .rst_n       (Clrn),
        .push_i      (enq),
        .pop_i       (pop),
        .flush_i     (RedirectValid),
        .push_pc_i   (pc_q),
        .push_inst_i (Inst),
        .count_o     (q_count),
        .head_pc_o   (head_pc),
        .head_inst_o (head_inst)
    );

    assign InstAddr   = pc_q;
    assign OutPc      = head_pc;
    assign OutInst    = head_inst;
    assign OutPcPlus4 = head_pc + PC_INC;

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            stall_cnt_q <= '0;
        end else if (OutValid && !OutReady && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign StallCnt = stall_cnt_q;
`else
    assign StallCnt = '0;
`endif

endmodule
